dma_s2mm_writer: RTL and testbench

//  Stream-to-memory DMA write master: accepts 64-bit beats on an AXI-Stream-like input, buffers
//  one burst, writes bursts to DDR over the Zynq AXI3 ACP write channels (AW/W/B). Write-direction

---
 rtl/dma_pkg.sv | 20 ++
 rtl/s2mm_sync_fifo.sv | 73 +++++++
 rtl/dma_s2mm_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_dma_s2mm_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared AXI3 ACP encodings and FSM state type for the S2MM write DMA.
package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [2:0] ACP_ID         = 3'b100;
  localparam logic [3:0] ACP_CACHE      = 4'b0001;
  localparam logic [2:0] ACP_PROT       = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StAddr,
    StData,
    StResp,
    StDone
  } dma_state_e;

endpackage

// File: rtl/s2mm_sync_fifo.sv
// Single-clock FIFO with occupancy count; asynchronous reset and synchronous flush
// both empty it. Head word is presented combinationally on rdata_o.
module s2mm_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap explicitly since DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dma_s2mm_writer.sv
// Stream-to-memory DMA: buffers one burst of 64-bit beats, then writes it over AXI3 ACP.
// Define DMA_S2MM_BRESP_CHECK_EN to flag error responses and abort the remaining bursts.
module dma_s2mm_writer
  import dma_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = 1280 * 720 * 3 / 8,
  parameter int unsigned DATA_SIZE_LOG = 19,
  parameter int unsigned BURST_SIZE    = 16
) (
  input  logic        m_axi_acp_aclk,
  input  logic        axi_resetn,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  m_axi_acp_awid,
  output logic [31:0] m_axi_acp_awaddr,
  output logic [3:0]  m_axi_acp_awlen,
  output logic [2:0]  m_axi_acp_awsize,
  output logic [1:0]  m_axi_acp_awburst,
  output logic [1:0]  m_axi_acp_awlock,
  output logic [3:0]  m_axi_acp_awcache,
  output logic [2:0]  m_axi_acp_awprot,
  output logic [3:0]  m_axi_acp_awqos,
  output logic [4:0]  m_axi_acp_awuser,
  output logic        m_axi_acp_awvalid,
  input  logic        m_axi_acp_awready,
  output logic [2:0]  m_axi_acp_wid,
  output logic [63:0] m_axi_acp_wdata,
  output logic [7:0]  m_axi_acp_wstrb,
  output logic        m_axi_acp_wlast,
  output logic [4:0]  m_axi_acp_wuser,
  output logic        m_axi_acp_wvalid,
  input  logic        m_axi_acp_wready,
  input  logic [2:0]  m_axi_acp_bid,
  input  logic [1:0]  m_axi_acp_bresp,
  input  logic [4:0]  m_axi_acp_buser,
  input  logic        m_axi_acp_bvalid,
  output logic        m_axi_acp_bready,
  input  logic [63:0] s2mm_data,
  input  logic        s2mm_valid,
  output logic        s2mm_ready
);

  localparam int unsigned TransNum   = DATA_SIZE / BURST_SIZE;
  localparam int unsigned BurstBytes = BURST_SIZE * 8;
  localparam int unsigned AlignBits  = $clog2(BurstBytes);
  localparam int unsigned FifoDepth  = 2 * BURST_SIZE;
  localparam int unsigned CntW       = $clog2(FifoDepth + 1);
  localparam int unsigned BeatW      = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam int unsigned CntDW      = DATA_SIZE_LOG;

  dma_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [CntDW-1:0]  accepted_q, accepted_d;
  logic [CntDW-1:0]  burst_idx_q, burst_idx_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic              bready_q, bready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [63:0]       fifo_rdata;
  logic [CntW-1:0]   fifo_count;
  logic              abort;
  logic              last_burst;
  logic              unused_b;

`ifdef DMA_S2MM_BRESP_CHECK_EN
  assign abort = (m_axi_acp_bresp != AXI_RESP_OKAY);
`else
  assign abort = 1'b0;
`endif

  assign unused_b   = ^{m_axi_acp_bid, m_axi_acp_buser, m_axi_acp_bresp, fifo_empty};
  assign last_burst = (burst_idx_q == CntDW'(TransNum - 1));
  assign s2mm_ready = busy_q & ~fifo_full & (accepted_q < CntDW'(DATA_SIZE));
  assign fifo_push  = s2mm_valid & s2mm_ready;
  assign fifo_pop   = wvalid_q & m_axi_acp_wready;

  s2mm_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FifoDepth),
    .CNT_W (CntW)
  ) u_fifo (
    .clk_i   (m_axi_acp_aclk),
    .rst_ni  (axi_resetn),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (s2mm_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    accepted_d  = accepted_q + CntDW'(fifo_push);
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    fifo_flush  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFill;
          addr_d      = {base_addr[31:AlignBits], {AlignBits{1'b0}}};
          accepted_d  = '0;
          burst_idx_d = '0;
          busy_d      = 1'b1;
          error_d     = 1'b0;
        end
      end
      StFill: begin
        if (fifo_count >= CntW'(BURST_SIZE)) begin
          state_d   = StAddr;
          awvalid_d = 1'b1;
        end
      end
      StAddr: begin
        if (m_axi_acp_awready) begin
          state_d   = StData;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (BURST_SIZE == 1);
          beat_d    = '0;
        end
      end
      StData: begin
        if (m_axi_acp_wready) begin
          if (wlast_q) begin
            state_d  = StResp;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            beat_d  = beat_q + BeatW'(1);
            // Look one beat ahead so wlast is a registered output.
            wlast_d = (beat_q == BeatW'(BURST_SIZE - 2));
          end
        end
      end
      StResp: begin
        if (m_axi_acp_bvalid) begin
          bready_d    = 1'b0;
          addr_d      = addr_q + 32'(BurstBytes);
          burst_idx_d = burst_idx_q + CntDW'(1);
          error_d     = error_q | abort;
          if (last_burst || abort) begin
            state_d    = StDone;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            fifo_flush = abort;
          end else begin
            state_d = StFill;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      accepted_q  <= '0;
      burst_idx_q <= '0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      accepted_q  <= accepted_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign m_axi_acp_awid    = ACP_ID;
  assign m_axi_acp_awaddr  = addr_q;
  assign m_axi_acp_awlen   = 4'(BURST_SIZE - 1);
  assign m_axi_acp_awsize  = AXI_SIZE_8B;
  assign m_axi_acp_awburst = AXI_BURST_INCR;
  assign m_axi_acp_awlock  = 2'b00;
  assign m_axi_acp_awcache = ACP_CACHE;
  assign m_axi_acp_awprot  = ACP_PROT;
  assign m_axi_acp_awqos   = 4'b0000;
  assign m_axi_acp_awuser  = 5'b00000;
  assign m_axi_acp_awvalid = awvalid_q;
  assign m_axi_acp_wid     = ACP_ID;
  assign m_axi_acp_wdata   = fifo_rdata;
  assign m_axi_acp_wstrb   = 8'hFF;
  assign m_axi_acp_wlast   = wlast_q;
  assign m_axi_acp_wuser   = 5'b00000;
  assign m_axi_acp_wvalid  = wvalid_q;
  assign m_axi_acp_bready  = bready_q;

endmodule

// File: tb/tb_dma_s2mm_writer.sv
// Randomized bench for dma_s2mm_writer: stream source, AXI3 slave and a queue-based
// scoreboard that predicts addresses, data order, wlast placement and done timing.
`timescale 1ns/1ps
module tb_dma_s2mm_writer;

  localparam int unsigned DS    = 32;
  localparam int unsigned BS    = 16;
  localparam int unsigned NB    = DS / BS;
  localparam int unsigned BYTES = BS * 8;
`ifdef DMA_S2MM_BRESP_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] base_addr;
  logic        busy, done, error;
  logic [2:0]  awid, awsize, awprot, wid, bid;
  logic [31:0] awaddr;
  logic [3:0]  awlen, awcache, awqos;
  logic [1:0]  awburst, awlock, bresp;
  logic [4:0]  awuser, wuser, buser;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] wdata, s2mm_data;
  logic [7:0]  wstrb;
  logic        s2mm_valid, s2mm_ready;

  always #5 clk = ~clk;

  dma_s2mm_writer #(
    .DATA_SIZE     (DS),
    .DATA_SIZE_LOG (6),
    .BURST_SIZE    (BS)
  ) dut (
    .m_axi_acp_aclk    (clk),
    .axi_resetn        (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .m_axi_acp_awid    (awid),
    .m_axi_acp_awaddr  (awaddr),
    .m_axi_acp_awlen   (awlen),
    .m_axi_acp_awsize  (awsize),
    .m_axi_acp_awburst (awburst),
    .m_axi_acp_awlock  (awlock),
    .m_axi_acp_awcache (awcache),
    .m_axi_acp_awprot  (awprot),
    .m_axi_acp_awqos   (awqos),
    .m_axi_acp_awuser  (awuser),
    .m_axi_acp_awvalid (awvalid),
    .m_axi_acp_awready (awready),
    .m_axi_acp_wid     (wid),
    .m_axi_acp_wdata   (wdata),
    .m_axi_acp_wstrb   (wstrb),
    .m_axi_acp_wlast   (wlast),
    .m_axi_acp_wuser   (wuser),
    .m_axi_acp_wvalid  (wvalid),
    .m_axi_acp_wready  (wready),
    .m_axi_acp_bid     (bid),
    .m_axi_acp_bresp   (bresp),
    .m_axi_acp_buser   (buser),
    .m_axi_acp_bvalid  (bvalid),
    .m_axi_acp_bready  (bready),
    .s2mm_data         (s2mm_data),
    .s2mm_valid        (s2mm_valid),
    .s2mm_ready        (s2mm_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus configuration
  int src_pct, wr_pct, aw_delay, b_delay, pause_at, pause_len, src_limit;
  bit bad_first, aw_rand, mon_en;
  // Scoreboard / model state
  logic [63:0] sent_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] aw_seen[$];
  int aw_hs, w_hs, w_in_burst, b_hs, b_owed, b_wait, aw_wait, wlast_cnt;
  int last_b_cyc, done_cnt, done_cyc, exp_bursts;
  int src_gen, src_acc, pause_cnt;
  bit exp_err, bv, src_vld, prev_aw_wait, prev_w_cont;
  logic [1:0]  br;
  logic [63:0] src_dat;
  logic [31:0] prev_awaddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sent_q.delete(); exp_addr_q.delete(); aw_seen.delete();
    aw_hs = 0; w_hs = 0; w_in_burst = 0; b_hs = 0; b_owed = 0; b_wait = 0; aw_wait = 0;
    wlast_cnt = 0; last_b_cyc = -100; bv = 1'b0; br = 2'b00;
    src_vld = 1'b0; src_gen = 0; src_acc = 0; pause_cnt = 0;
    prev_aw_wait = 1'b0; prev_w_cont = 1'b0;
  endtask

  task automatic cfg(input int sp, input int wp, input int ad, input int bd, input int pa,
                     input int pl, input bit bad, input int lim, input bit ar);
    src_pct = sp; wr_pct = wp; aw_delay = ad; b_delay = bd; pause_at = pa;
    pause_len = pl; bad_first = bad; src_limit = lim; aw_rand = ar;
  endtask

  // Expected addresses come from plain arithmetic on the aligned base.
  task automatic start_xfer(input logic [31:0] base);
    logic [31:0] aligned;
    @(posedge clk); #1;
    model_reset();
    aligned = base & ~32'(BYTES - 1);
    for (int i = 0; i < int'(NB); i++) exp_addr_q.push_back(aligned + 32'(i * BYTES));
    exp_err    = bad_first && ChkEn;
    exp_bursts = exp_err ? 1 : int'(NB);
    mon_en = 1'b1;
    @(negedge clk); #1 start = 1'b1; base_addr = base;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no done pulse after %0d cycles, required one", name, n);
    end
    repeat (3) @(negedge clk);
    #1 chk({name, "_idle_busy"}, busy, 0);
  endtask

  // Slave + source driver and per-cycle checker; decisions are made mid-cycle so that
  // the handshakes recorded here are the ones the DUT sees at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      s2mm_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    end else begin
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk("done_busy", busy, 0);
        chk("done_aw_count", aw_hs, exp_bursts);
        chk("done_w_count", w_hs, exp_bursts * BS);
        chk("done_b_count", b_hs, exp_bursts);
        chk("done_lag", cyc - last_b_cyc, 1);
        chk("done_error", error, exp_err);
      end
      if (s2mm_ready) chk("ready_needs_busy", busy, 1);
      if (prev_aw_wait) chk("aw_stable", {awvalid, awaddr}, {1'b1, prev_awaddr});
      if (prev_w_cont) chk("w_steady", wvalid, 1);
      if (wvalid) chk("w_after_aw", aw_hs > (w_hs / int'(BS)), 1);
      if (awvalid) chk("aw_one_outstanding", aw_hs == b_hs, 1);

      // AW slave
      if (awvalid) begin
        awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        awready = 1'b0;
      end
      if (awvalid && awready) begin
        if (exp_addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL aw_extra: got AW at %0h, required no AW", awaddr);
        end else begin
          chk("aw_addr", awaddr, exp_addr_q.pop_front());
        end
        chk("aw_const", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser},
            {3'b100, 4'(BS - 1), 3'b011, 2'b01, 2'b00, 4'b0001, 3'b010, 4'b0, 5'b0});
        chk("aw_buffered", (src_acc - w_hs) >= int'(BS), 1);
        aw_seen.push_back(awaddr);
        aw_hs++; aw_wait = 0;
        if (aw_rand) aw_delay = $urandom_range(3);
      end

      // B slave (before W so a response never precedes its last beat)
      if (!bv && b_owed > 0) begin
        if (b_wait >= b_delay) begin
          bv = 1'b1;
          br = (bad_first && b_hs == 0) ? 2'b10 : 2'b00;
        end else begin
          b_wait++;
        end
      end
      bvalid = bv; bresp = br;
      if (bv && bready) begin
        b_hs++; b_owed--; last_b_cyc = cyc; bv = 1'b0; b_wait = 0;
      end

      // W slave
      wready = ($urandom_range(99) < wr_pct);
      if (wvalid && wready) begin
        if (sent_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL w_extra: got beat %0h, required none", wdata);
        end else begin
          chk("w_data", wdata, sent_q.pop_front());
        end
        chk("w_last", wlast, (w_in_burst == int'(BS) - 1));
        chk("w_const", {wid, wstrb, wuser}, {3'b100, 8'hFF, 5'b0});
        if (wlast) wlast_cnt++;
        if (w_in_burst == int'(BS) - 1) begin
          b_owed++; w_in_burst = 0;
        end else begin
          w_in_burst++;
        end
        w_hs++;
      end

      // Stream source
      if (!src_vld && src_gen < src_limit) begin
        if (src_gen == pause_at && pause_cnt < pause_len) begin
          pause_cnt++;
        end else if ($urandom_range(99) < src_pct) begin
          src_vld = 1'b1; src_dat = {$urandom(), $urandom()}; src_gen++;
        end
      end
      s2mm_valid = src_vld; s2mm_data = src_dat;
      if (src_vld && s2mm_ready) begin
        sent_q.push_back(src_dat); src_acc++; src_vld = 1'b0;
      end

      prev_aw_wait = awvalid && !awready;
      prev_awaddr  = awaddr;
      prev_w_cont  = wvalid && !(wready && wlast);
    end
  end

  initial begin
    int d0;
    int n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; mon_en = 1'b0;
    bid = 3'b100; buser = '0; s2mm_data = '0; done_cnt = 0; done_cyc = 0;
    exp_err = 1'b0; exp_bursts = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 chk("rst_outputs", {awvalid, wvalid, wlast, bready, busy, done, error, s2mm_ready}, 0);
    chk("rst_consts", {awlen, awsize, awcache, wstrb}, {4'd15, 3'b011, 4'b0001, 8'hFF});
    rst_n = 1'b1;

    // 1: continuous stream, always-ready slave, two extra beats offered beyond DATA_SIZE
    cfg(100, 100, 0, 0, -1, 0, 1'b0, DS + 2, 1'b0);
    d0 = done_cnt;
    start_xfer(32'h1000_0000);
    wait_done("t1", d0);
    chk("t1_aw0", (aw_seen.size() > 0) ? aw_seen[0] : 32'hx, 32'h1000_0000);
    chk("t1_aw1", (aw_seen.size() > 1) ? aw_seen[1] : 32'hx, 32'h1000_0080);
    chk("t1_wlast_count", wlast_cnt, 2);
    chk("t1_beats", w_hs, 32);
    chk("t1_done_lag", done_cyc - last_b_cyc, 1);
    chk("t1_not_consumed", {src_vld, 26'(src_acc)}, {1'b1, 26'd32});

    // 2: stall after 10 beats; low address bits ignored
    cfg(100, 100, 0, 1, 10, 20, 1'b0, DS, 1'b0);
    d0 = done_cnt;
    start_xfer(32'h2000_0047);
    wait_done("t2", d0);
    chk("t2_aw0", (aw_seen.size() > 0) ? aw_seen[0] : 32'hx, 32'h2000_0000);

    // 3: slow awready
    cfg(100, 100, 5, 0, -1, 0, 1'b0, DS, 1'b0);
    d0 = done_cnt;
    start_xfer(32'h3000_0100);
    wait_done("t3", d0);

    // 4: random readiness plus a start pulse while busy that must be ignored
    cfg(70, 50, 1, 2, -1, 0, 1'b0, DS, 1'b1);
    d0 = done_cnt;
    start_xfer(32'h5555_5580);
    repeat (10) @(negedge clk);
    #1 start = 1'b1; base_addr = 32'hDEAD_0000;
    @(negedge clk); #1 start = 1'b0;
    wait_done("t4", d0);

    // 4b: address wraps modulo 2^32
    cfg(60, 60, 0, 0, -1, 0, 1'b0, DS, 1'b1);
    d0 = done_cnt;
    start_xfer(32'hFFFF_FF80);
    wait_done("t4b", d0);
    chk("t4b_wrap", (aw_seen.size() > 1) ? aw_seen[1] : 32'hx, 32'h0000_0000);

    // 5: error response on the first burst
    cfg(100, 100, 0, 0, -1, 0, 1'b1, DS, 1'b0);
    d0 = done_cnt;
    start_xfer(32'h4000_0000);
    wait_done("t5", d0);
    chk("t5_error_sticky", error, ChkEn);
    chk("t5_bursts", aw_seen.size(), ChkEn ? 1 : 2);

    // 5b: next start clears error
    cfg(80, 80, 0, 0, -1, 0, 1'b0, DS, 1'b0);
    d0 = done_cnt;
    start_xfer(32'h4000_1000);
    wait_done("t5b", d0);

    // 6: reset during the data phase, then a clean restart
    cfg(90, 90, 0, 0, -1, 0, 1'b0, DS, 1'b0);
    start_xfer(32'h6000_0000);
    n = 0;
    while (w_hs < 7 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reached_beat7", w_hs >= 7, 1);
    mon_en = 1'b0;
    @(negedge clk); #1;
    chk("t6_wvalid_before", wvalid, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_async", {awvalid, wvalid, wlast, bready, busy, done, error, s2mm_ready}, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1 chk("t6_idle_after_rst", busy, 0);
    cfg(75, 65, 2, 1, -1, 0, 1'b0, DS, 1'b1);
    d0 = done_cnt;
    start_xfer(32'h6000_0200);
    wait_done("t6b", d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
